// File: rtl/mem_arbiter_pkg.sv
// Shared constants and request type for the data-RAM arbiter slice.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_WIDTH = 15;
  localparam int MEM_DATA_WIDTH = 8;

  localparam int PORT_CORE  = 0;
  localparam int PORT_STACK = 1;
  localparam int PORT_DSP   = 2;

  typedef struct packed {
    logic                      write;
    logic                      lock;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Rotate-priority picker: first valid port at or after rr_ptr, wrapping.
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between requesters,
// with locked bursts so multi-byte stack sequences stay atomic.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int LOCK_MAX   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      lock_owner;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      next_rr;
  logic                  lock_active;
  logic [CNT_W-1:0]      lock_cnt;
  logic [CNT_W-1:0]      next_cnt;
  logic [NUM_REQ-1:0]    pick_valid;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rsp_id;
  logic                  any_grant;
  logic                  accept;
  logic                  g_write;
  logic                  g_lock;
  logic                  lock_done;
  logic [DATA_WIDTH-1:0] rdata_hold;

  // While a burst is locked only its owner is visible to the picker.
  assign pick_valid = lock_active ? (req_valid & (NUM_REQ'(1) << lock_owner)) : req_valid;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid     (pick_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_grant)
  );

  assign accept    = any_grant && !reset;
  assign req_ready = accept ? grant : '0;
  assign g_write   = req_write[grant_idx];
  assign g_lock    = req_lock[grant_idx];

  assign mem_en    = accept;
  assign mem_we    = accept && g_write;
  assign mem_addr  = accept ? req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_wdata = accept ? req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  // A burst ends on an unlocked beat or when it reaches LOCK_MAX beats.
  assign next_cnt  = lock_active ? lock_cnt + 1'b1 : CNT_W'(1);
  assign lock_done = !g_lock || (next_cnt == CNT_W'(LOCK_MAX));
  assign next_rr   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= '0;
      lock_active <= 1'b0;
      lock_owner  <= '0;
      lock_cnt    <= '0;
    end else if (accept) begin
      if (lock_done) begin
        lock_active <= 1'b0;
        lock_cnt    <= '0;
        rr_ptr      <= next_rr;
      end else begin
        lock_active <= 1'b1;
        lock_owner  <= grant_idx;
        lock_cnt    <= next_cnt;
      end
    end
  end

  // Read pipe: remember which port asked, RAM data arrives next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_id     <= '0;
      rdata_hold <= '0;
    end else begin
      rsp_id <= (accept && !g_write) ? grant : '0;
      if (|rsp_id) rdata_hold <= mem_rdata;
    end
  end

  assign rsp_valid = reset ? '0 : rsp_id;
  assign rsp_rdata = reset ? '0 : ((|rsp_id) ? mem_rdata : rdata_hold);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queue-based requesters, reference model, RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = MEM_ADDR_WIDTH;
  localparam int DW = MEM_DATA_WIDTH;
  localparam int LM = 4;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_write, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Single-port RAM the arbiter drives.
  bit [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_exp_t;

  typedef struct {
    int            cyc;
    int            port;
    logic [DW-1:0] data;
  } rsp_exp_t;

  mem_req_t   port_q [N][$];
  grant_exp_t grant_q[$];
  rsp_exp_t   rsp_q[$];
  int         dut_log[$];

  int          m_rr, m_owner, m_beats;
  bit          m_lock_on;
  bit [DW-1:0] model_mem [0:(1<<AW)-1];

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int model_pick();
    if (m_lock_on) return (port_q[m_owner].size() > 0) ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int p = (m_rr + k) % N;
      if (port_q[p].size() > 0) return p;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (port_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus; the model decides the grant and queues expectations.
  task automatic applyStimulus(input bit rst);
    grant_exp_t g;
    rsp_exp_t   e;
    mem_req_t   r;
    int         p;
    @(posedge clock);
    #1;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      if (port_q[i].size() > 0) begin
        r = port_q[i][0];
        req_valid[i] = 1'b1;
        req_write[i] = r.write;
        req_lock[i]  = r.lock;
        req_addr[i*AW +: AW]  = r.addr;
        req_wdata[i*DW +: DW] = r.wdata;
      end else begin
        req_valid[i] = 1'b0;
        req_write[i] = 1'b0;
        req_lock[i]  = 1'b0;
        req_addr[i*AW +: AW]  = '0;
        req_wdata[i*DW +: DW] = '0;
      end
    end
    g.port = -1; g.we = 1'b0; g.addr = '0; g.wdata = '0;
    if (rst) begin
      m_rr = 0; m_lock_on = 1'b0; m_beats = 0;
      while (rsp_q.size() > 0 && rsp_q[rsp_q.size()-1].cyc == cyc) void'(rsp_q.pop_back());
      grant_q.push_back(g);
      return;
    end
    p = model_pick();
    if (p >= 0) begin
      r = port_q[p].pop_front();
      g.port = p; g.we = r.write; g.addr = r.addr; g.wdata = r.wdata;
      if (r.write) model_mem[r.addr] = r.wdata;
      else begin
        e.cyc = cyc + 1; e.port = p; e.data = model_mem[r.addr];
        rsp_q.push_back(e);
      end
      if (r.lock) begin
        if (!m_lock_on) begin m_lock_on = 1'b1; m_owner = p; m_beats = 0; end
        m_beats++;
        if (m_beats == LM) begin m_lock_on = 1'b0; m_rr = (p + 1) % N; end
      end else begin
        m_lock_on = 1'b0;
        m_rr = (p + 1) % N;
      end
    end
    grant_q.push_back(g);
  endtask

  function automatic mem_req_t mk(input bit w, input bit l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_req_t r;
    r.write = w; r.lock = l; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic mem_req_t rand_req(input bit allow_lock);
    mem_req_t r;
    r.write = 1'($urandom);
    r.lock  = allow_lock && ($urandom_range(0, 3) == 0);
    r.addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
    r.wdata = DW'($urandom);
    return r;
  endfunction

  // Drain all requester queues; an idle lock owner finishes its burst with an unlocked beat.
  task automatic runIdle(input int max_cycles, input bit close_locks);
    int n = 0;
    while (any_pending() && n < max_cycles) begin
      if (close_locks && m_lock_on && port_q[m_owner].size() == 0)
        port_q[m_owner].push_back(mk(1'b0, 1'b0, '0, '0));
      applyStimulus(1'b0);
      n++;
    end
    if (any_pending()) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain_timeout: queues still pending after %0d cycles", max_cycles);
    end
  endtask

  task automatic checkLog(input string name, input int expv[$]);
    @(negedge clock);
    #1;
    checkOutput({name, "_len"}, dut_log.size(), expv.size());
    for (int i = 0; i < expv.size() && i < dut_log.size(); i++)
      checkOutput($sformatf("%s_grant%0d", name, i), dut_log[i], expv[i]);
  endtask

  // Monitor: compares every cycle against the queued expectations.
  grant_exp_t    mon_g;
  rsp_exp_t      mon_r;
  logic [DW-1:0] last_rdata = '0;

  always @(negedge clock) begin
    if (grant_q.size() > 0) begin
      mon_g = grant_q.pop_front();
      checkOutput("req_ready", req_ready, (mon_g.port >= 0) ? (64'd1 << mon_g.port) : 64'd0);
      checkOutput("mem_en", mem_en, mon_g.port >= 0);
      if (mon_g.port >= 0)
        checkOutput("mem_beat", {mem_we, mem_addr, mem_wdata}, {mon_g.we, mon_g.addr, mon_g.wdata});
      if (mem_en) dut_log.push_back(onehot_idx(req_ready));
    end
    if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
      mon_r = rsp_q.pop_front();
      checkOutput("rsp_cycle", cyc, mon_r.cyc);
      checkOutput("rsp_valid", rsp_valid, 64'd1 << mon_r.port);
      checkOutput("rsp_rdata", rsp_rdata, mon_r.data);
      last_rdata = mon_r.data;
    end else begin
      checkOutput("rsp_idle", rsp_valid, 0);
      checkOutput("rsp_hold", rsp_rdata, reset ? '0 : last_rdata);
    end
    if (reset) last_rdata = '0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0;
    m_rr = 0; m_lock_on = 1'b0; m_owner = 0; m_beats = 0;

    $display("[TB] reset with all ports requesting");
    for (int i = 0; i < N; i++) port_q[i].push_back(rand_req(1'b0));
    repeat (3) applyStimulus(1'b1);
    dut_log.delete();
    runIdle(20, 1'b1);
    checkLog("reset_first", '{0, 1, 2});

    $display("[TB] write then read same address from another port");
    applyStimulus(1'b1);
    port_q[PORT_STACK].push_back(mk(1'b1, 1'b0, 15'h7FFF, 8'hA5));
    applyStimulus(1'b0);
    port_q[PORT_CORE].push_back(mk(1'b0, 1'b0, 15'h7FFF, 8'h00));
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    $display("[TB] all ports continuously valid");
    applyStimulus(1'b1);
    for (int i = 0; i < N; i++) repeat (3) port_q[i].push_back(rand_req(1'b0));
    dut_log.delete();
    runIdle(20, 1'b1);
    checkLog("round_robin", '{0, 1, 2, 0, 1, 2, 0, 1, 2});

    $display("[TB] two-byte locked stack push");
    applyStimulus(1'b1);
    dut_log.delete();
    port_q[PORT_CORE].push_back(rand_req(1'b0));
    applyStimulus(1'b0);
    port_q[PORT_STACK].push_back(mk(1'b1, 1'b1, 15'h0100, 8'h11));
    port_q[PORT_STACK].push_back(mk(1'b1, 1'b0, 15'h0101, 8'h22));
    port_q[PORT_CORE].push_back(rand_req(1'b0));
    port_q[PORT_DSP].push_back(rand_req(1'b0));
    runIdle(20, 1'b1);
    checkLog("lock_pair", '{0, 1, 1, 2, 0});

    $display("[TB] lock held past LOCK_MAX");
    applyStimulus(1'b1);
    dut_log.delete();
    repeat (6) port_q[PORT_DSP].push_back(mk(1'b0, 1'b1, AW'($urandom), 8'h00));
    applyStimulus(1'b0);
    port_q[PORT_CORE].push_back(rand_req(1'b0));
    port_q[PORT_STACK].push_back(rand_req(1'b0));
    runIdle(20, 1'b0);
    checkLog("lock_max", '{2, 2, 2, 2, 0, 1, 2, 2});

    $display("[TB] reset right after an accepted read");
    applyStimulus(1'b1);
    port_q[PORT_DSP].push_back(mk(1'b0, 1'b0, 15'h0042, 8'h00));
    applyStimulus(1'b0);
    for (int i = 0; i < N; i++) port_q[i].push_back(rand_req(1'b0));
    applyStimulus(1'b1);
    dut_log.delete();
    runIdle(20, 1'b1);
    checkLog("post_reset", '{0, 1, 2});

    $display("[TB] randomized traffic");
    applyStimulus(1'b1);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (port_q[i].size() < 2 && $urandom_range(0, 2) == 0) port_q[i].push_back(rand_req(1'b1));
      applyStimulus($urandom_range(0, 99) == 0);
    end
    runIdle(200, 1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    @(negedge clock);
    #1;
    checkOutput("grant_q_left", grant_q.size(), 0);
    checkOutput("rsp_q_left", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
